// File: rtl/fp_div_nr_seq.sv
// -----------------------------------------------------------------------------
// fp_div_nr_seq
//   Multi-cycle IEEE-754 single-precision divider. It seeds a reciprocal
//   estimate of the divisor, refines it with NUM_ITER Newton-Raphson steps
//   x' = x*(2 - b*x) using one shared multiplier and one subtractor, and then
//   multiplies the refined reciprocal by the dividend. Subnormal operands are
//   flushed to zero, and results below the normal range are flushed to zero.
//   Rounding is round-to-nearest-even in every arithmetic step.
//
//   Compile-time option:
//     FP_DIV_EARLY_EXIT_EN  when defined, stop refining as soon as an
//                           iteration leaves x bit-identical; latency then
//                           varies. When undefined, exactly NUM_ITER steps run.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. The producer holds its payload stable while
//   valid is high and ready is low; ready never depends combinationally on
//   valid.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        synchronous reset, active-low
//     in_valid     operands valid
//     in_ready     high when idle and able to accept operands
//     dividend     numerator a (IEEE-754 single)
//     divisor      denominator b (IEEE-754 single)
//     out_valid    quotient valid
//     out_ready    consumer accepts quotient
//     quotient     a/b (IEEE-754 single)
//     div_by_zero  finite nonzero a divided by zero b, qualified by out_valid
//     busy         high in every state except IDLE
//     dbg_state    current FSM state encoding
// -----------------------------------------------------------------------------
module fp_div_nr_seq #(
  parameter int NUM_ITER = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEED   = 3'd1,
    S_MUL_BX = 3'd2,
    S_SUB    = 3'd3,
    S_MUL_X  = 3'd4,
    S_FINAL  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [2:0]  LAST_CNT = 3'(NUM_ITER);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ftz(input logic [31:0] f);
    ftz = (f[30:23] == 8'd0) ? {f[31], 31'd0} : f;
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] p;
    logic [22:0] m;
    logic        g, st;
    logic [23:0] r;
    int          e;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    // Product of two [1,2) significands lies in [1,4): normalise by one bit.
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {1'b0, m} + {23'd0, g & (st | m[0])};
    if (r[23]) e = e + 1;
    if (a_nan || b_nan)                          fp_mul = QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) fp_mul = QNAN;
    else if (a_inf || b_inf)                     fp_mul = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                   fp_mul = {s, 31'd0};
    else if (e >= 255)                           fp_mul = {s, 8'hFF, 23'd0};
    else if (e <= 0)                             fp_mul = {s, 31'd0};
    else                                         fp_mul = {s, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  d;
    logic [50:0] mb, ms;
    logic [51:0] sum, norm;
    logic [23:0] r;
    logic        g, st;
    int          lz, e;
    fp_add = 32'd0;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d    = big[30:23] - sml[30:23];
    mb   = {1'b1, big[22:0], 27'd0};
    // Beyond 27 positions the smaller operand only contributes a sticky bit.
    ms   = (d > 8'd27) ? 51'd1 : ({1'b1, sml[22:0], 27'd0} >> d);
    sum  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    lz   = 0;
    for (int i = 0; i < 52; i++) begin
      if (sum[i]) lz = 51 - i;
    end
    norm = sum << lz;
    e    = int'(big[30:23]) + 1 - lz;
    g    = norm[27];
    st   = |norm[26:0];
    r    = {1'b0, norm[50:28]} + {23'd0, g & (st | norm[28])};
    if (r[23]) e = e + 1;
    if (a_nan || b_nan)             fp_add = QNAN;
    else if (a_inf && b_inf)        fp_add = (a[31] != b[31]) ? QNAN : a;
    else if (a_inf)                 fp_add = a;
    else if (b_inf)                 fp_add = b;
    else if (sml[30:23] == 8'd0)    fp_add = (big[30:23] == 8'd0) ? {big[31] & sml[31], 31'd0} : big;
    else if (sum == 52'd0)          fp_add = 32'd0;
    else if (e >= 255)              fp_add = {big[31], 8'hFF, 23'd0};
    else if (e <= 0)                fp_add = {big[31], 31'd0};
    else                            fp_add = {big[31], e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    fp_sub = fp_add(a, {~b[31], b[30:0]});
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] x_q, x_d;
  logic [31:0] t_q, t_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic        dbz_q, dbz_d;
  logic        spec_q, spec_d;

  logic [31:0] mul_a, mul_b, mul_y, sub_y;
  logic        spec_hit, spec_dbz;
  logic [31:0] spec_res;

  // Special-operand classification on the registered (already flushed) operands.
  always_comb begin
    logic sq;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    sq       = a_q[31] ^ b_q[31];
    a_nan    = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan    = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_zero   = (a_q[30:23] == 8'd0);
    b_zero   = (b_q[30:23] == 8'd0);
    spec_hit = 1'b1;
    spec_dbz = 1'b0;
    spec_res = 32'd0;
    if (a_nan || b_nan)           spec_res = QNAN;
    else if (b_zero && a_zero)    spec_res = QNAN;
    else if (b_zero) begin
      spec_res = {sq, 8'hFF, 23'd0};
      spec_dbz = ~a_inf;
    end
    else if (b_inf && a_inf)      spec_res = QNAN;
    else if (b_inf || a_zero)     spec_res = {sq, 31'd0};
    else if (a_inf)               spec_res = {sq, 8'hFF, 23'd0};
    // The seed exponent 253-eb would leave the normal range.
    else if (b_q[30:23] >= 8'd253) spec_res = {sq, 31'd0};
    else                          spec_hit = 1'b0;
  end

  // Shared multiplier operand select, and the shared subtractor.
  always_comb begin
    mul_a = x_q;
    mul_b = t_q;
    case (state_q)
      S_MUL_BX: begin mul_a = b_q; mul_b = x_q; end
      S_FINAL:  begin mul_a = a_q; mul_b = x_q; end
      default:  ;
    endcase
    mul_y = fp_mul(mul_a, mul_b);
    sub_y = fp_sub(FP_TWO, t_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    spec_d  = spec_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = ftz(dividend);
          b_d     = ftz(divisor);
          dbz_d   = 1'b0;
          spec_d  = 1'b0;
          state_d = S_SEED;
        end
      end
      S_SEED: begin
        if (spec_hit) begin
          // Special results are committed here and pass through FINAL,
          // which leaves the multiplier result unused for them.
          quot_d  = spec_res;
          dbz_d   = spec_dbz;
          spec_d  = 1'b1;
          state_d = S_FINAL;
        end else begin
          // 2^(126-eb'): places b*x0 in [0.5,1), so the first error is <= 0.5.
          x_d     = {b_q[31], 8'd253 - b_q[30:23], 23'd0};
          cnt_d   = 3'd0;
          state_d = S_MUL_BX;
        end
      end
      S_MUL_BX: begin
        t_d     = mul_y;
        state_d = S_SUB;
      end
      S_SUB: begin
        t_d     = sub_y;
        state_d = S_MUL_X;
      end
      S_MUL_X: begin
        x_d     = mul_y;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q + 3'd1 == LAST_CNT) state_d = S_FINAL;
        else                          state_d = S_MUL_BX;
`ifdef FP_DIV_EARLY_EXIT_EN
        if (mul_y == x_q) state_d = S_FINAL;
`endif
      end
      S_FINAL: begin
        if (!spec_q) quot_d = mul_y;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      x_q     <= 32'd0;
      t_q     <= 32'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 32'd0;
      dbz_q   <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      spec_q  <= spec_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp_div_nr_seq.sv
module tb_fp_div_nr_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (NUM_ITER = 5)
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] dividend = '0, divisor = '0, quotient;
  logic        div_by_zero, busy;
  logic [2:0]  dbg_state;

  // Seven-iteration instance for the latency / early-exit case
  logic        in_valid7 = 1'b0, in_ready7, out_valid7, out_ready7 = 1'b1;
  logic [31:0] dividend7 = '0, divisor7 = '0, quotient7;
  logic        dbz7, busy7;
  logic [2:0]  dbg_state7;

  fp_div_nr_seq #(.NUM_ITER(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .div_by_zero(div_by_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  fp_div_nr_seq #(.NUM_ITER(7)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid7), .in_ready(in_ready7),
    .dividend(dividend7), .divisor(divisor7),
    .out_valid(out_valid7), .out_ready(out_ready7),
    .quotient(quotient7), .div_by_zero(dbz7),
    .busy(busy7), .dbg_state(dbg_state7)
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Reference model: real-valued division rounded to single, FTZ
  // ---------------------------------------------------------------------------
  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_sp(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b0, d[51:29]} + {23'd0, d[28] & ((|d[27:0]) | d[29])};
    if (m[23]) e++;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  // tol = 0 marks an exact (special-case) result.
  function automatic void ref_div(input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] q, output logic dbz, output int tol);
    logic [31:0] a, b;
    logic s;
    a = (a_in[30:23] == 8'd0) ? {a_in[31], 31'd0} : a_in;
    b = (b_in[30:23] == 8'd0) ? {b_in[31], 31'd0} : b_in;
    s = a[31] ^ b[31];
    dbz = 1'b0;
    tol = 0;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) q = 32'h7FC00000;
    else if (b[30:0] == 0 && a[30:0] == 0) q = 32'h7FC00000;
    else if (b[30:0] == 0) begin q = {s, 8'hFF, 23'd0}; dbz = (a[30:23] != 8'hFF); end
    else if (b[30:0] == 31'h7F800000 && a[30:0] == 31'h7F800000) q = 32'h7FC00000;
    else if (b[30:0] == 31'h7F800000 || a[30:0] == 0) q = {s, 31'd0};
    else if (a[30:0] == 31'h7F800000) q = {s, 8'hFF, 23'd0};
    else if (b[30:23] >= 8'd253) q = {s, 31'd0};
    else begin
      q = to_sp(to_real(a) / to_real(b));
      tol = 1;
    end
  endfunction

  function automatic bit close(input logic [31:0] act, input logic [31:0] exp, input int tol);
    int da, de;
    if (tol == 0) return act == exp;
    if (act[31] != exp[31]) return 1'b0;
    da = int'(act[30:0]);
    de = int'(exp[30:0]);
    return (da - de <= tol) && (de - da <= tol);
  endfunction

  // ---------------------------------------------------------------------------
  // Checkers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    checks++;
    if (!close(act, exp, tol)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (tol %0d ulp)", name, act, exp, tol);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat, input int lo, input int hi);
    checks++;
    if (lat < lo || lat > hi) begin
      errors++;
      $display("FAIL %s: latency %0d edges, expected %0d..%0d", name, lat, lo, hi);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a negedge, returns at the negedge where out_valid is seen.
  // lat = edges from the accept edge to out_valid high.
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid7 = 1'b0;
    out_ready = 1'b1;
    out_ready7 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic dbz, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk_bit({name, "_in_ready"}, in_ready, 1'b1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_bit({name, "_busy"}, busy, 1'b1);
    chk_bit({name, "_dbz_clear"}, div_by_zero, 1'b0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid=0 expected 1 within 200 edges", name);
    end
    q   = quotient;
    dbz = div_by_zero;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    int          lat;
    int          tol;
  } vec_t;

  localparam int NV = 13;
  localparam int RAND_N = 40;
  // Single-precision NR is not correctly rounded; a few ulps of slack.
  localparam int RAND_TOL = 3;

  logic [31:0] exp_q[$];
  logic        exp_dbz_q[$];
  int          exp_tol_q[$];

  initial begin
    vec_t        vecs[NV];
    logic [31:0] q, eq, q_hold;
    logic        dbz, edbz;
    int          lat, etol, lo, stale;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 17, 1}; // 6/2
    vecs[1]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2, 0};  // 1/0
    vecs[2]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 2, 0};  // 0/0
    vecs[3]  = '{32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 2, 0};  // -0/3
    vecs[4]  = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b0, 2, 0};  // 1/NaN
    vecs[5]  = '{32'hC1200000, 32'h40800000, 32'hC0200000, 1'b0, 17, 1}; // -10/4
    vecs[6]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 2, 0};  // inf/-inf
    vecs[7]  = '{32'h40A00000, 32'h7F800000, 32'h00000000, 1'b0, 2, 0};  // 5/inf
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 2, 0};  // -inf/2
    vecs[9]  = '{32'h3F800000, 32'h7E800000, 32'h00000000, 1'b0, 2, 0};  // exp(b)=253
    vecs[10] = '{32'h40000000, 32'h00000001, 32'h7F800000, 1'b1, 2, 0};  // 2/subnormal
    vecs[11] = '{32'hC0400000, 32'hBFC00000, 32'h40000000, 1'b0, 17, 1}; // -3/-1.5
    vecs[12] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 17, 1}; // 1/3

    do_reset();

    // Reset state
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_dbz", div_by_zero, 1'b0);
    chk("rst_quotient", quotient, 32'h0, 0);
    chk_bit("rst7_in_ready", in_ready7, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, q, dbz, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q, vecs[i].tol);
      chk_bit($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
      lo = vecs[i].lat;
`ifdef FP_DIV_EARLY_EXIT_EN
      if (vecs[i].lat > 2) lo = 5;
`endif
      chk_lat($sformatf("vec%0d_lat", i), lat, lo, vecs[i].lat);
      chk_bit($sformatf("vec%0d_no_accept_in_done", i), in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk_bit($sformatf("vec%0d_idle_after", i), in_ready, 1'b1);
      chk_bit($sformatf("vec%0d_ov_drop", i), out_valid, 1'b0);
    end

    // Back-pressure: 1/3 held for 10 cycles
    out_ready = 1'b0;
    run_op("bp", 32'h3F800000, 32'h40400000, q, dbz, lat);
    chk("bp_q", q, 32'h3EAAAAAB, 1);
    q_hold = quotient;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c), quotient, q_hold, 0);
      chk_bit($sformatf("bp_ov%0d", c), out_valid, 1'b1);
      chk_bit($sformatf("bp_inr%0d", c), in_ready, 1'b0);
      chk_bit($sformatf("bp_busy%0d", c), busy, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_bit("bp_release_ov", out_valid, 1'b0);
    chk_bit("bp_release_inr", in_ready, 1'b1);

    // Reset in the middle of 7/5
    dividend = 32'h40E00000;
    divisor  = 32'h40A00000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_bit("midrst_ov", out_valid, 1'b0);
    chk_bit("midrst_inr", in_ready, 1'b1);
    chk_bit("midrst_busy", busy, 1'b0);
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midrst_no_output", 32'(stale), 32'd0, 0);
    run_op("after_rst", 32'hC1200000, 32'h40800000, q, dbz, lat);
    chk("after_rst_q", q, 32'hC0200000, 1);
    @(posedge clk);
    @(negedge clk);

    // NUM_ITER = 7 instance: 1.0/1.0
    dividend7 = 32'h3F800000;
    divisor7  = 32'h3F800000;
    in_valid7 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid7 = 1'b0;
    lat = 0;
    while (!out_valid7 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk_bit("it7_valid", out_valid7, 1'b1);
    chk("it7_q", quotient7, 32'h3F800000, 0);
`ifdef FP_DIV_EARLY_EXIT_EN
    chk_lat("it7_lat", lat, 5, 22);
`else
    chk_lat("it7_lat", lat, 23, 23);
`endif
    @(posedge clk);
    @(negedge clk);

    // Randomised operands against the reference model, via the scoreboard
    for (int n = 0; n < RAND_N; n++) begin
      logic [31:0] ra, rb;
      ra = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
      if ($urandom_range(0, 9) == 0) rb = {rb[31], 31'd0};
      ref_div(ra, rb, eq, edbz, etol);
      exp_q.push_back(eq);
      exp_dbz_q.push_back(edbz);
      exp_tol_q.push_back(etol == 0 ? 0 : RAND_TOL);
      run_op($sformatf("rnd%0d", n), ra, rb, q, dbz, lat);
      eq   = exp_q.pop_front();
      edbz = exp_dbz_q.pop_front();
      etol = exp_tol_q.pop_front();
      chk($sformatf("rnd%0d_q(%h/%h)", n, ra, rb), q, eq, etol);
      chk_bit($sformatf("rnd%0d_dbz", n), dbz, edbz);
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
